// File: rtl/alu_op_driver_if.sv
// alu_op_driver_if: command, ALU and response signals of the ALU command issuer.
// The slave modport is the issuer itself. The master modport is its environment:
// the command source, the attached combinational ALU and the response sink.
interface alu_op_driver_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [3:0] cmd_a;
  logic [3:0] cmd_b;
  logic       cmd_acc;

  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [2:0] alu_sel;
  logic [3:0] alu_result;
  logic       alu_carry;

  logic       rsp_valid;
  logic       rsp_ready;
  logic [3:0] rsp_result;
  logic       rsp_carry;
  logic       rsp_zero;

  logic [3:0] acc;
  logic       busy;
  logic       chk_err;

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_acc,
    output alu_result, alu_carry,
    output rsp_ready,
    input  cmd_ready, alu_a, alu_b, alu_sel,
    input  rsp_valid, rsp_result, rsp_carry, rsp_zero,
    input  acc, busy, chk_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_acc,
    input  alu_result, alu_carry,
    input  rsp_ready,
    output cmd_ready, alu_a, alu_b, alu_sel,
    output rsp_valid, rsp_result, rsp_carry, rsp_zero,
    output acc, busy, chk_err
  );
endinterface

// File: rtl/alu_op_driver.sv
// alu_op_driver: issues commands to a 4-bit combinational ALU, holds its inputs
// for SETTLE_CYCLES clocks, samples Result/CarryOut and returns them on a
// valid/ready response channel. A 4-bit accumulator keeps the last result.
// Optional macro ALU_DRV_CHECK_EN adds a golden model that sets the sticky
// chk_err flag when the ALU disagrees with it; without it chk_err is tied low.
module alu_op_driver #(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  alu_op_driver_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);

  // Settle times outside 1..15 cannot be represented by the 4-bit counter.
  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
    $error("alu_op_driver: SETTLE_CYCLES=%0d outside legal range 1..15", SETTLE_CYCLES);
  end

  state_t     state;
  logic [3:0] settle_cnt;
  logic       cmd_ready_q;
  logic       rsp_valid_q;
  logic       busy_q;
  logic [3:0] alu_a_q;
  logic [3:0] alu_b_q;
  logic [2:0] alu_sel_q;
  logic [3:0] rsp_result_q;
  logic       rsp_carry_q;
  logic       rsp_zero_q;
  logic [3:0] acc_q;
  logic       sample_now;

  // The ALU outputs are captured on the last settle cycle.
  assign sample_now = (state == SETTLE) && (settle_cnt == 4'd1);

  // Command/settle/response sequencer with registered handshake and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      settle_cnt   <= 4'd0;
      cmd_ready_q  <= 1'b1;
      rsp_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      alu_a_q      <= 4'd0;
      alu_b_q      <= 4'd0;
      alu_sel_q    <= 3'd0;
      rsp_result_q <= 4'd0;
      rsp_carry_q  <= 1'b0;
      rsp_zero_q   <= 1'b0;
      acc_q        <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            alu_a_q     <= bus.cmd_acc ? acc_q : bus.cmd_a;
            alu_b_q     <= bus.cmd_b;
            alu_sel_q   <= bus.cmd_op;
            settle_cnt  <= SETTLE_LOAD;
            state       <= SETTLE;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b1;
          end
        end
        SETTLE: begin
          if (settle_cnt == 4'd1) begin
            rsp_result_q <= bus.alu_result;
            rsp_carry_q  <= bus.alu_carry;
            rsp_zero_q   <= (bus.alu_result == 4'd0);
            acc_q        <= bus.alu_result;
            settle_cnt   <= 4'd0;
            state        <= RESP;
            rsp_valid_q  <= 1'b1;
          end else begin
            settle_cnt <= settle_cnt - 4'd1;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            state       <= IDLE;
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          settle_cnt  <= 4'd0;
          rsp_valid_q <= 1'b0;
          cmd_ready_q <= 1'b1;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cmd_ready  = cmd_ready_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.busy       = busy_q;
  assign bus.alu_a      = alu_a_q;
  assign bus.alu_b      = alu_b_q;
  assign bus.alu_sel    = alu_sel_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_carry  = rsp_carry_q;
  assign bus.rsp_zero   = rsp_zero_q;
  assign bus.acc        = acc_q;

`ifdef ALU_DRV_CHECK_EN
  logic [4:0] model_out;
  logic       chk_err_q;

  // Golden {carry, result} for the operation currently presented to the ALU.
  always_comb begin
    model_out = 5'd0;
    case (alu_sel_q)
      3'b000:  model_out = {1'b0, alu_a_q} + {1'b0, alu_b_q};
      3'b001:  model_out = {1'b0, alu_a_q} - {1'b0, alu_b_q};
      3'b010:  model_out = {1'b0, alu_a_q & alu_b_q};
      3'b011:  model_out = {1'b0, alu_a_q | alu_b_q};
      3'b100:  model_out = {1'b0, alu_a_q ^ alu_b_q};
      3'b101:  model_out = {1'b0, alu_a_q[2:0], 1'b0};
      3'b110:  model_out = {2'b00, alu_a_q[3:1]};
      default: model_out = {1'b0, ~alu_a_q};
    endcase
  end

  // Sticky mismatch flag, only cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chk_err_q <= 1'b0;
    end else if (sample_now && ({bus.alu_carry, bus.alu_result} != model_out)) begin
      chk_err_q <= 1'b1;
    end
  end

  assign bus.chk_err = chk_err_q;
`else
  assign bus.chk_err = 1'b0;
`endif

endmodule
